avalon_mm_master: RTL and testbench
===================================

// Module: avalon_mm_master
// PURPOSE
//  Avalon-MM master (initiator). Turns a simple command/response interface into Avalon-MM
//  read/write transfers with wait-state and pipelined read (READDATAVALID, burst) support.
//  Pairs with the team's register slaves: drives ADDRESS/READ/WRITE, consumes WAITREQUEST/READDATA.
//  Sits between a local controller (sequencer, DMA, CPU bridge) and the Avalon fabric.
// PARAMETERS
//  ADDR_WIDTH   32  Avalon address width (byte address)
//  DATA_WIDTH   32  data width; byte enables = DATA_WIDTH/8
//  BURST_WIDTH  3   BURSTCOUNT width; max burst = 2**BURST_WIDTH-1
//  MAX_PENDING  4   max read beats outstanding (issued, not yet returned); also burst-length FIFO depth
// PORTS
//  CLK                 in   1            clock, all logic on posedge
//  RESET               in   1            asynchronous, active-high
//  CMD_VALID           in   1            command present
//  CMD_READY           out  1            command accepted when CMD_VALID && CMD_READY
//  CMD_WRITE           in   1            1 = write, 0 = read
//  CMD_ADDRESS         in   ADDR_WIDTH   target address
//  CMD_WRITEDATA       in   DATA_WIDTH   write data
//  CMD_BYTE_ENABLE     in   DATA_WIDTH/8 byte enables
//  CMD_BURSTCOUNT      in   BURST_WIDTH  read burst length; ignored for writes
//  RSP_VALID           out  1            read data beat valid (one cycle per beat)
//  RSP_DATA            out  DATA_WIDTH   read data beat
//  RSP_LAST            out  1            final beat of its read burst
//  ERROR               out  1            sticky: READDATAVALID seen with nothing pending
//  ADDRESS             out  ADDR_WIDTH   Avalon address
//  BYTE_ENABLE         out  DATA_WIDTH/8 Avalon byte enables
//  READ / WRITE        out  1 each       Avalon read / write strobes
//  WRITEDATA           out  DATA_WIDTH   Avalon write data
//  BURSTCOUNT          out  BURST_WIDTH  Avalon burst count
//  BEGINBURSTTRANSFER  out  1            high on first cycle of each transfer only
//  WAITREQUEST         in   1            slave stall
//  READDATA            in   DATA_WIDTH   slave read data
//  READDATAVALID       in   1            slave read data valid
// BEHAVIOUR
//  Reset: all outputs and registered state 0 (pending count, FIFO pointers, FSM = IDLE);
//   CMD_READY gated low while RESET high. Reset mid-transfer aborts; in-flight beats are dropped.
//  FSM IDLE -> REQ on command accept; REQ -> IDLE on cycle with WAITREQUEST=0. No other states.
//  CMD_READY (comb) = IDLE && (CMD_WRITE || pending + eff_burst <= MAX_PENDING) && !fifo_full.
//  Accept edge: register ADDRESS, BYTE_ENABLE, WRITEDATA, BURSTCOUNT; assert READ or WRITE.
//   eff_burst = CMD_BURSTCOUNT, 0 coerced to 1. Writes always BURSTCOUNT=1.
//   BEGINBURSTTRANSFER=1 only on first REQ cycle.
//  REQ: all Avalon outputs held stable while WAITREQUEST=1. Transfer taken at the edge where
//   WAITREQUEST=0; READ/WRITE low next cycle. Min 2 cycles per command (accept, issue).
//  Pending counter: +eff_burst on read taken, -1 per READDATAVALID; same-cycle events net
//   (never underflows). Burst-length FIFO (MAX_PENDING deep) pushed on read taken, popped on last beat.
//  Response: RSP_VALID/RSP_DATA registered, 1 cycle after READDATAVALID. RSP_LAST when beat count
//   equals FIFO head length; beat count then clears. Writes produce no response.
//  READDATAVALID with pending=0: ignored (no RSP_VALID), ERROR set, cleared only by RESET.
//  Writes may issue while reads are outstanding; slave returns read data in order.
// TESTING
//  1 write 0x4/0xDEADBEEF/BE=1111, WAITREQUEST=0 -> WRITE high 1 cycle, BURSTCOUNT=1, BEGINBURSTTRANSFER 1 cycle, CMD_READY high next.
//  2 write 0x8, WAITREQUEST high 3 cycles -> outputs stable 4 cycles, WRITE drops cycle after WAITREQUEST low.
//  3 read 0x8 burst 4; 4 beats 0x1..0x4 with gaps -> 4 RSP_VALID pulses, each 1 cycle late; RSP_LAST on 4th only.
//  4 MAX_PENDING=4: read burst 2 then burst 3 -> 2nd held (CMD_READY=0) until 1 beat back; RSP_LAST on beats 2 and 5.
//  5 READDATAVALID with nothing pending -> no RSP_VALID; ERROR=1 until RESET.
//  6 RESET mid-burst after beat 1 of 4 -> outputs 0 at once; after release pending=0, CMD_READY=1, late beats set ERROR.

Source files
------------

// File: rtl/avalon_mm_master.sv
// ---------------------------------------------------------------------------
// avalon_mm_master
//
// Avalon-MM initiator. Converts a valid/ready command interface into Avalon-MM
// read and write transfers. It honours WAITREQUEST stalls and supports pipelined
// read bursts returned through READDATAVALID.
//
// Ports
//   CLK, RESET                     clock (posedge) and asynchronous active-high reset
//   CMD_VALID / CMD_READY          command handshake; accepted when both high
//   CMD_WRITE                      1 = write, 0 = read
//   CMD_ADDRESS, CMD_WRITEDATA     target byte address and write data
//   CMD_BYTE_ENABLE                byte enables for the transfer
//   CMD_BURSTCOUNT                 read burst length (0 treated as 1), ignored on writes
//   RSP_VALID, RSP_DATA, RSP_LAST  registered read beats, last beat of each burst flagged
//   ERROR                          sticky: READDATAVALID arrived with nothing outstanding
//   ADDRESS, BYTE_ENABLE, READ, WRITE, WRITEDATA, BURSTCOUNT, BEGINBURSTTRANSFER
//                                  Avalon-MM request side
//   WAITREQUEST, READDATA, READDATAVALID
//                                  Avalon-MM slave responses
// ---------------------------------------------------------------------------
module avalon_mm_master #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int BURST_WIDTH = 3,
  parameter int MAX_PENDING = 4
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    CMD_VALID,
  output logic                    CMD_READY,
  input  logic                    CMD_WRITE,
  input  logic [ADDR_WIDTH-1:0]   CMD_ADDRESS,
  input  logic [DATA_WIDTH-1:0]   CMD_WRITEDATA,
  input  logic [DATA_WIDTH/8-1:0] CMD_BYTE_ENABLE,
  input  logic [BURST_WIDTH-1:0]  CMD_BURSTCOUNT,
  output logic                    RSP_VALID,
  output logic [DATA_WIDTH-1:0]   RSP_DATA,
  output logic                    RSP_LAST,
  output logic                    ERROR,
  output logic [ADDR_WIDTH-1:0]   ADDRESS,
  output logic [DATA_WIDTH/8-1:0] BYTE_ENABLE,
  output logic                    READ,
  output logic                    WRITE,
  output logic [DATA_WIDTH-1:0]   WRITEDATA,
  output logic [BURST_WIDTH-1:0]  BURSTCOUNT,
  output logic                    BEGINBURSTTRANSFER,
  input  logic                    WAITREQUEST,
  input  logic [DATA_WIDTH-1:0]   READDATA,
  input  logic                    READDATAVALID
);

  localparam int PEND_W = $clog2(MAX_PENDING + 1);
  localparam int PTR_W  = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
  localparam int CMP_W  = PEND_W + BURST_WIDTH;

  typedef enum logic {
    IDLE,
    REQ
  } state_t;

  state_t state, state_next;

  logic [PEND_W-1:0]      pending;
  logic [PEND_W-1:0]      fifo_count;
  logic [BURST_WIDTH-1:0] fifo_mem [MAX_PENDING];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [BURST_WIDTH-1:0] beat_cnt;
  logic [BURST_WIDTH-1:0] eff_burst;

  logic credit_ok;
  logic fifo_full;
  logic cmd_accept;
  logic xfer_taken;
  logic rd_taken;
  logic beat_valid;
  logic beat_last;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_PENDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // Read credit check and response-side decode. A read is only accepted when
  // its whole burst fits under the outstanding-beat limit. A READDATAVALID with
  // nothing outstanding is not a real beat, so it never reaches the response path.
  always_comb begin
    eff_burst  = (CMD_BURSTCOUNT == '0) ? BURST_WIDTH'(1) : CMD_BURSTCOUNT;
    credit_ok  = (CMP_W'(pending) + CMP_W'(eff_burst)) <= CMP_W'(MAX_PENDING);
    fifo_full  = (fifo_count == PEND_W'(MAX_PENDING));
    beat_valid = READDATAVALID && (pending != '0);
    beat_last  = beat_valid && ((beat_cnt + 1'b1) == fifo_mem[rd_ptr]);
  end

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  // Next state and handshake. A command is accepted only in IDLE. REQ ends on
  // the first cycle the slave is not stalling.
  always_comb begin
    state_next = state;
    CMD_READY  = 1'b0;
    xfer_taken = 1'b0;
    case (state)
      IDLE: begin
        CMD_READY = !RESET && (CMD_WRITE || credit_ok) && !fifo_full;
        if (CMD_VALID && CMD_READY) state_next = REQ;
      end
      REQ: begin
        if (!WAITREQUEST) begin
          xfer_taken = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    cmd_accept = CMD_VALID && CMD_READY;
    rd_taken   = xfer_taken && READ;
  end

  // Avalon request registers. These are captured at accept and held through
  // any stall. Only the strobes drop once the slave takes the transfer.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ADDRESS            <= '0;
      BYTE_ENABLE        <= '0;
      WRITEDATA          <= '0;
      BURSTCOUNT         <= '0;
      READ               <= 1'b0;
      WRITE              <= 1'b0;
      BEGINBURSTTRANSFER <= 1'b0;
    end else if (cmd_accept) begin
      ADDRESS            <= CMD_ADDRESS;
      BYTE_ENABLE        <= CMD_BYTE_ENABLE;
      WRITEDATA          <= CMD_WRITEDATA;
      BURSTCOUNT         <= CMD_WRITE ? BURST_WIDTH'(1) : eff_burst;
      READ               <= !CMD_WRITE;
      WRITE              <= CMD_WRITE;
      BEGINBURSTTRANSFER <= 1'b1;
    end else begin
      BEGINBURSTTRANSFER <= 1'b0;
      if (xfer_taken) begin
        READ  <= 1'b0;
        WRITE <= 1'b0;
      end
    end
  end

  // Outstanding-beat counter and burst-length FIFO. An issued burst and a
  // returning beat in the same cycle net together. The FIFO head holds the length of
  // the burst currently returning, so it is popped on that burst's last beat.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pending    <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      for (int i = 0; i < MAX_PENDING; i++) fifo_mem[i] <= '0;
    end else begin
      pending    <= pending + (rd_taken ? PEND_W'(BURSTCOUNT) : '0) - PEND_W'(beat_valid);
      fifo_count <= fifo_count + PEND_W'(rd_taken) - PEND_W'(beat_last);
      if (rd_taken) begin
        fifo_mem[wr_ptr] <= BURSTCOUNT;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (beat_last) rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  // Response path: beats are re-timed by one cycle. The beat counter restarts
  // after each burst's final beat. ERROR latches on a beat that nobody asked for.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      RSP_VALID <= 1'b0;
      RSP_DATA  <= '0;
      RSP_LAST  <= 1'b0;
      beat_cnt  <= '0;
      ERROR     <= 1'b0;
    end else begin
      RSP_VALID <= beat_valid;
      RSP_LAST  <= beat_last;
      if (beat_valid) begin
        RSP_DATA <= READDATA;
        beat_cnt <= beat_last ? '0 : beat_cnt + 1'b1;
      end
      if (READDATAVALID && (pending == '0)) ERROR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_avalon_mm_master.sv
// ---------------------------------------------------------------------------
// tb_avalon_mm_master
//
// Directed bench for avalon_mm_master. Inputs change on the falling edge.
// Registered outputs are checked on the falling edge before new inputs are applied.
// The combinational CMD_READY is checked 1 ns after the inputs settle.
// ---------------------------------------------------------------------------
module tb_avalon_mm_master;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic        CMD_WRITE;
  logic [31:0] CMD_ADDRESS;
  logic [31:0] CMD_WRITEDATA;
  logic [3:0]  CMD_BYTE_ENABLE;
  logic [2:0]  CMD_BURSTCOUNT;
  logic        RSP_VALID;
  logic [31:0] RSP_DATA;
  logic        RSP_LAST;
  logic        ERROR;
  logic [31:0] ADDRESS;
  logic [3:0]  BYTE_ENABLE;
  logic        READ;
  logic        WRITE;
  logic [31:0] WRITEDATA;
  logic [2:0]  BURSTCOUNT;
  logic        BEGINBURSTTRANSFER;
  logic        WAITREQUEST;
  logic [31:0] READDATA;
  logic        READDATAVALID;

  int compared   = 0;
  int mismatched = 0;

  avalon_mm_master #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .BURST_WIDTH(3),
    .MAX_PENDING(4)
  ) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .CMD_VALID         (CMD_VALID),
    .CMD_READY         (CMD_READY),
    .CMD_WRITE         (CMD_WRITE),
    .CMD_ADDRESS       (CMD_ADDRESS),
    .CMD_WRITEDATA     (CMD_WRITEDATA),
    .CMD_BYTE_ENABLE   (CMD_BYTE_ENABLE),
    .CMD_BURSTCOUNT    (CMD_BURSTCOUNT),
    .RSP_VALID         (RSP_VALID),
    .RSP_DATA          (RSP_DATA),
    .RSP_LAST          (RSP_LAST),
    .ERROR             (ERROR),
    .ADDRESS           (ADDRESS),
    .BYTE_ENABLE       (BYTE_ENABLE),
    .READ              (READ),
    .WRITE             (WRITE),
    .WRITEDATA         (WRITEDATA),
    .BURSTCOUNT        (BURSTCOUNT),
    .BEGINBURSTTRANSFER(BEGINBURSTTRANSFER),
    .WAITREQUEST       (WAITREQUEST),
    .READDATA          (READDATA),
    .READDATAVALID     (READDATAVALID)
  );

  // Free-running clock, 10 ns period.
  always #5 CLK = ~CLK;

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive the command side of the DUT.
  task automatic applyStimulus(input logic valid, input logic wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] be,
                               input logic [2:0] burst);
    CMD_VALID       = valid;
    CMD_WRITE       = wr;
    CMD_ADDRESS     = addr;
    CMD_WRITEDATA   = data;
    CMD_BYTE_ENABLE = be;
    CMD_BURSTCOUNT  = burst;
  endtask

  // Drive the slave-response side of the DUT.
  task automatic slaveDrive(input logic wr, input logic rdv, input logic [31:0] data);
    WAITREQUEST   = wr;
    READDATAVALID = rdv;
    READDATA      = data;
  endtask

  // One comparison: the observed value must equal the expected value.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    RESET = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'd0);
    slaveDrive(1'b0, 1'b0, 32'h0);

    // ---------------- Reset state ----------------
    @(negedge CLK);
    @(negedge CLK);
    #1;
    checkOutput("rst_cmd_ready", CMD_READY, 0);
    checkOutput("rst_read", READ, 0);
    checkOutput("rst_write", WRITE, 0);
    checkOutput("rst_rsp_valid", RSP_VALID, 0);
    checkOutput("rst_error", ERROR, 0);
    checkOutput("rst_address", ADDRESS, 0);
    checkOutput("rst_burstcount", BURSTCOUNT, 0);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    checkOutput("post_rst_ready", CMD_READY, 1);

    // ---------------- 1: simple write, no stall ----------------
    @(negedge CLK);
    applyStimulus(1'b1, 1'b1, 32'h4, 32'hDEADBEEF, 4'hF, 3'd0);
    #1;
    checkOutput("t1_ready", CMD_READY, 1);
    @(negedge CLK);
    checkOutput("t1_write", WRITE, 1);
    checkOutput("t1_read", READ, 0);
    checkOutput("t1_address", ADDRESS, 32'h4);
    checkOutput("t1_wdata", WRITEDATA, 32'hDEADBEEF);
    checkOutput("t1_be", BYTE_ENABLE, 4'hF);
    checkOutput("t1_burst", BURSTCOUNT, 1);
    checkOutput("t1_bbt", BEGINBURSTTRANSFER, 1);
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 3'd0);
    #1;
    checkOutput("t1_ready_req", CMD_READY, 0);
    @(negedge CLK);
    checkOutput("t1_write_drop", WRITE, 0);
    checkOutput("t1_bbt_drop", BEGINBURSTTRANSFER, 0);
    checkOutput("t1_ready_next", CMD_READY, 1);

    // ---------------- 2: write with 3 stall cycles ----------------
    applyStimulus(1'b1, 1'b1, 32'h8, 32'h12345678, 4'h3, 3'd5);
    slaveDrive(1'b1, 1'b0, 32'h0);
    @(negedge CLK);
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 3'd0);
    checkOutput("t2_write_c1", WRITE, 1);
    checkOutput("t2_bbt_c1", BEGINBURSTTRANSFER, 1);
    checkOutput("t2_addr_c1", ADDRESS, 32'h8);
    checkOutput("t2_burst_c1", BURSTCOUNT, 1);
    @(negedge CLK);
    checkOutput("t2_write_c2", WRITE, 1);
    checkOutput("t2_bbt_c2", BEGINBURSTTRANSFER, 0);
    checkOutput("t2_addr_c2", ADDRESS, 32'h8);
    @(negedge CLK);
    checkOutput("t2_write_c3", WRITE, 1);
    checkOutput("t2_wdata_c3", WRITEDATA, 32'h12345678);
    @(negedge CLK);
    checkOutput("t2_write_c4", WRITE, 1);
    checkOutput("t2_be_c4", BYTE_ENABLE, 4'h3);
    slaveDrive(1'b0, 1'b0, 32'h0);
    @(negedge CLK);
    checkOutput("t2_write_drop", WRITE, 0);

    // ---------------- 3: read burst 4 with gaps ----------------
    applyStimulus(1'b1, 1'b0, 32'h8, 32'h0, 4'hF, 3'd4);
    #1;
    checkOutput("t3_ready", CMD_READY, 1);
    @(negedge CLK);
    checkOutput("t3_read", READ, 1);
    checkOutput("t3_burst", BURSTCOUNT, 4);
    checkOutput("t3_addr", ADDRESS, 32'h8);
    checkOutput("t3_bbt", BEGINBURSTTRANSFER, 1);
    applyStimulus(1'b0, 1'b0, 32'h8, 32'h0, 4'hF, 3'd4);
    @(negedge CLK);
    checkOutput("t3_read_drop", READ, 0);
    #1;
    checkOutput("t3_ready_full", CMD_READY, 0);
    slaveDrive(1'b0, 1'b1, 32'h1);
    @(negedge CLK);
    checkOutput("t3_b1_valid", RSP_VALID, 1);
    checkOutput("t3_b1_data", RSP_DATA, 32'h1);
    checkOutput("t3_b1_last", RSP_LAST, 0);
    slaveDrive(1'b0, 1'b0, 32'h0);
    @(negedge CLK);
    checkOutput("t3_gap_valid", RSP_VALID, 0);
    slaveDrive(1'b0, 1'b1, 32'h2);
    @(negedge CLK);
    checkOutput("t3_b2_valid", RSP_VALID, 1);
    checkOutput("t3_b2_data", RSP_DATA, 32'h2);
    checkOutput("t3_b2_last", RSP_LAST, 0);
    slaveDrive(1'b0, 1'b1, 32'h3);
    @(negedge CLK);
    checkOutput("t3_b3_data", RSP_DATA, 32'h3);
    checkOutput("t3_b3_last", RSP_LAST, 0);
    slaveDrive(1'b0, 1'b0, 32'h0);
    @(negedge CLK);
    checkOutput("t3_gap2_valid", RSP_VALID, 0);
    slaveDrive(1'b0, 1'b1, 32'h4);
    @(negedge CLK);
    checkOutput("t3_b4_valid", RSP_VALID, 1);
    checkOutput("t3_b4_data", RSP_DATA, 32'h4);
    checkOutput("t3_b4_last", RSP_LAST, 1);
    slaveDrive(1'b0, 1'b0, 32'h0);
    @(negedge CLK);
    checkOutput("t3_end_valid", RSP_VALID, 0);
    checkOutput("t3_end_last", RSP_LAST, 0);
    #1;
    checkOutput("t3_ready_free", CMD_READY, 1);

    // ---------------- 4: burst 2 then burst 3, credit limit ----------------
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 3'd2);
    @(negedge CLK);
    checkOutput("t4_read1", READ, 1);
    checkOutput("t4_burst1", BURSTCOUNT, 2);
    applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, 4'hF, 3'd3);
    #1;
    checkOutput("t4_ready_req", CMD_READY, 0);
    @(negedge CLK);
    checkOutput("t4_read1_drop", READ, 0);
    #1;
    checkOutput("t4_ready_held", CMD_READY, 0);
    slaveDrive(1'b0, 1'b1, 32'hA1);
    @(negedge CLK);
    checkOutput("t4_b1_data", RSP_DATA, 32'hA1);
    checkOutput("t4_b1_last", RSP_LAST, 0);
    checkOutput("t4_read_still_low", READ, 0);
    slaveDrive(1'b0, 1'b0, 32'h0);
    #1;
    checkOutput("t4_ready_released", CMD_READY, 1);
    @(negedge CLK);
    checkOutput("t4_read2", READ, 1);
    checkOutput("t4_burst2", BURSTCOUNT, 3);
    checkOutput("t4_addr2", ADDRESS, 32'h20);
    checkOutput("t4_bbt2", BEGINBURSTTRANSFER, 1);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'd0);
    slaveDrive(1'b0, 1'b1, 32'hA2);
    @(negedge CLK);
    checkOutput("t4_b2_valid", RSP_VALID, 1);
    checkOutput("t4_b2_data", RSP_DATA, 32'hA2);
    checkOutput("t4_b2_last", RSP_LAST, 1);
    checkOutput("t4_read2_drop", READ, 0);
    slaveDrive(1'b0, 1'b1, 32'hB1);
    @(negedge CLK);
    checkOutput("t4_b3_data", RSP_DATA, 32'hB1);
    checkOutput("t4_b3_last", RSP_LAST, 0);
    slaveDrive(1'b0, 1'b1, 32'hB2);
    @(negedge CLK);
    checkOutput("t4_b4_data", RSP_DATA, 32'hB2);
    checkOutput("t4_b4_last", RSP_LAST, 0);
    slaveDrive(1'b0, 1'b1, 32'hB3);
    @(negedge CLK);
    checkOutput("t4_b5_valid", RSP_VALID, 1);
    checkOutput("t4_b5_data", RSP_DATA, 32'hB3);
    checkOutput("t4_b5_last", RSP_LAST, 1);
    slaveDrive(1'b0, 1'b0, 32'h0);
    @(negedge CLK);
    checkOutput("t4_end_valid", RSP_VALID, 0);
    checkOutput("t4_no_error", ERROR, 0);

    // ---------------- 5: stray READDATAVALID ----------------
    slaveDrive(1'b0, 1'b1, 32'h55);
    @(negedge CLK);
    checkOutput("t5_no_rsp", RSP_VALID, 0);
    checkOutput("t5_error", ERROR, 1);
    slaveDrive(1'b0, 1'b0, 32'h0);
    @(negedge CLK);
    checkOutput("t5_error_sticky", ERROR, 1);
    RESET = 1'b1;
    #1;
    checkOutput("t5_error_reset", ERROR, 0);
    @(negedge CLK);
    RESET = 1'b0;

    // ---------------- 6: reset in the middle of a burst ----------------
    @(negedge CLK);
    applyStimulus(1'b1, 1'b0, 32'h30, 32'h0, 4'hF, 3'd4);
    @(negedge CLK);
    checkOutput("t6_read", READ, 1);
    applyStimulus(1'b0, 1'b0, 32'h30, 32'h0, 4'hF, 3'd4);
    @(negedge CLK);
    slaveDrive(1'b0, 1'b1, 32'h77);
    @(negedge CLK);
    checkOutput("t6_b1_valid", RSP_VALID, 1);
    checkOutput("t6_b1_data", RSP_DATA, 32'h77);
    slaveDrive(1'b0, 1'b0, 32'h0);
    RESET = 1'b1;
    #1;
    checkOutput("t6_rst_rsp_valid", RSP_VALID, 0);
    checkOutput("t6_rst_rsp_data", RSP_DATA, 0);
    checkOutput("t6_rst_address", ADDRESS, 0);
    checkOutput("t6_rst_burst", BURSTCOUNT, 0);
    checkOutput("t6_rst_ready", CMD_READY, 0);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    checkOutput("t6_ready_after", CMD_READY, 1);
    slaveDrive(1'b0, 1'b1, 32'h88);
    @(negedge CLK);
    checkOutput("t6_late_no_rsp", RSP_VALID, 0);
    checkOutput("t6_late_error", ERROR, 1);
    slaveDrive(1'b0, 1'b0, 32'h0);

    @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
